// File: rtl/seg_pkg.sv
// Shared definitions for the balance-loop controller blocks: default widths
// and gains, soft-start increments, saturation direction and a signed clip helper.
package seg_pkg;

  localparam int DEF_IN_W    = 16;
  localparam int DEF_ERR_W   = 10;
  localparam int DEF_INT_W   = 18;
  localparam int DEF_OUT_W   = 12;
  localparam int DEF_P_COEFF = 9;
  localparam int DEF_I_SHIFT = 6;
  localparam int DEF_D_SHIFT = 6;
  localparam int DEF_LONG_W  = 27;
  localparam int DEF_SS_W    = 8;

  // Soft-start counter step: fast for simulation, slow for the real ramp
  localparam int SS_INC_FAST = 256;
  localparam int SS_INC_SLOW = 1;

  // Direction of the most recent output clip
  typedef enum logic {
    SAT_POS = 1'b0,
    SAT_NEG = 1'b1
  } sat_dir_e;

  // Clip a signed value into the signed range of 'width' bits (width <= 32)
  function automatic logic signed [31:0] sat_s(input logic signed [31:0] value,
                                               input int width);
    logic signed [31:0] max_v;
    logic signed [31:0] min_v;
    max_v = (32'sd1 <<< (width - 1)) - 32'sd1;
    min_v = -max_v - 32'sd1;
    if (value > max_v)
      return max_v;
    else if (value < min_v)
      return min_v;
    else
      return value;
  endfunction

endpackage

// File: rtl/soft_start_tmr.sv
// Soft-start ramp: a free-running counter that climbs while pwr_up is high
// and freezes once its top SS_W bits are all ones. The exposed level is the
// top SS_W bits of the counter.
module soft_start_tmr
  import seg_pkg::*;
#(
  parameter int LONG_W   = DEF_LONG_W,
  parameter int SS_W     = DEF_SS_W,
  parameter int FAST_SIM = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pwr_up,
  output logic [SS_W-1:0] ss_tmr
);

  localparam logic [LONG_W-1:0] INC = (FAST_SIM != 0) ? LONG_W'(SS_INC_FAST)
                                                      : LONG_W'(SS_INC_SLOW);

  logic [LONG_W-1:0] cnt_reg;
  logic              top_full;

  assign top_full = &cnt_reg[LONG_W-1 -: SS_W];

  // Ramp counter: cleared while power is down, frozen once the level is full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_reg <= '0;
    else if (!pwr_up)
      cnt_reg <= '0;
    else if (!top_full)
      cnt_reg <= cnt_reg + INC;
  end

  assign ss_tmr = cnt_reg[LONG_W-1 -: SS_W];

endmodule

// File: rtl/pid_ctrl_param.sv
// Two-stage pipelined PID for the balance loop. Stage 1 clips the pitch
// error, forms the D term and updates the integrator (overflow hold plus
// optional conditional-integration anti-windup). Stage 2 sums P, I and D,
// clips to the output width and reports whether it clipped.
module pid_ctrl_param
  import seg_pkg::*;
#(
  parameter int IN_W     = DEF_IN_W,
  parameter int ERR_W    = DEF_ERR_W,
  parameter int INT_W    = DEF_INT_W,
  parameter int OUT_W    = DEF_OUT_W,
  parameter int P_COEFF  = DEF_P_COEFF,
  parameter int I_SHIFT  = DEF_I_SHIFT,
  parameter int D_SHIFT  = DEF_D_SHIFT,
  parameter int LONG_W   = DEF_LONG_W,
  parameter int SS_W     = DEF_SS_W,
  parameter int FAST_SIM = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    vld_in,
  input  logic signed [IN_W-1:0]  ptch,
  input  logic signed [IN_W-1:0]  ptch_rt,
  input  logic                    pwr_up,
  input  logic                    rider_off,
  input  logic                    aw_en,
  output logic                    vld_out,
  output logic signed [OUT_W-1:0] PID_cntrl,
  output logic                    sat_flag,
  output logic [SS_W-1:0]         ss_tmr
);

  localparam int SUM_W = OUT_W + 5;
  localparam int D_W   = IN_W + 1;   // one extra bit so negating the most negative rate cannot wrap
  localparam logic signed [5:0] P_S = $signed({1'b0, 5'(P_COEFF)});

  // Stage 1 state
  logic signed [ERR_W-1:0] err_reg;
  logic signed [D_W-1:0]   d_reg;
  logic signed [INT_W-1:0] integ_reg;
  logic                    vld1_reg;

  // Stage 2 state
  sat_dir_e                sat_dir_reg;

  // Stage 1 combinational terms
  logic signed [ERR_W-1:0] err_next;
  logic signed [D_W-1:0]   d_next;
  logic signed [INT_W-1:0] cand;
  logic                    ovf;
  logic                    aw_hold;
  sat_dir_e                err_dir;

  assign err_next = ERR_W'(sat_s(32'(ptch), ERR_W));
  assign d_next   = -(D_W'(ptch_rt >>> D_SHIFT));
  assign cand     = integ_reg + INT_W'(err_next);
  assign err_dir  = err_next[ERR_W-1] ? SAT_NEG : SAT_POS;
  // Same-sign operands with a sign flip in the result means the add wrapped
  assign ovf      = (integ_reg[INT_W-1] == err_next[ERR_W-1]) &&
                    (cand[INT_W-1] != integ_reg[INT_W-1]);
  // Registered sat_flag is used here, so the hold engages one sample late
  assign aw_hold  = aw_en && sat_flag && (err_dir == sat_dir_reg);

  // Stage 1: capture error and D term, update integrator unless held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg   <= '0;
      d_reg     <= '0;
      integ_reg <= '0;
      vld1_reg  <= 1'b0;
    end else if (rider_off) begin
      integ_reg <= '0;
      vld1_reg  <= 1'b0;
    end else begin
      vld1_reg <= vld_in;
      if (vld_in) begin
        err_reg <= err_next;
        d_reg   <= d_next;
        if (!ovf && !aw_hold)
          integ_reg <= cand;
      end
    end
  end

  // Stage 2 combinational terms; the integrator seen here is already post-update
  logic signed [SUM_W-1:0] p_term;
  logic signed [SUM_W-1:0] i_term;
  logic signed [SUM_W-1:0] d_term;
  logic signed [SUM_W-1:0] sum;
  logic signed [OUT_W-1:0] pid_next;
  logic                    clip;

  assign p_term   = SUM_W'(err_reg) * SUM_W'(P_S);
  assign i_term   = SUM_W'(integ_reg >>> I_SHIFT);
  assign d_term   = SUM_W'(d_reg);
  assign sum      = p_term + i_term + d_term;
  assign pid_next = OUT_W'(sat_s(32'(sum), OUT_W));
  assign clip     = (32'(pid_next) != 32'(sum));

  // Stage 2: register saturated command, clip flag, direction and output strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PID_cntrl   <= '0;
      sat_flag    <= 1'b0;
      sat_dir_reg <= SAT_POS;
      vld_out     <= 1'b0;
    end else if (rider_off) begin
      PID_cntrl <= '0;
      sat_flag  <= 1'b0;
      vld_out   <= 1'b0;
    end else begin
      vld_out <= vld1_reg;
      if (vld1_reg) begin
        PID_cntrl   <= pid_next;
        sat_flag    <= clip;
        sat_dir_reg <= sum[SUM_W-1] ? SAT_NEG : SAT_POS;
      end
    end
  end

  soft_start_tmr #(
    .LONG_W  (LONG_W),
    .SS_W    (SS_W),
    .FAST_SIM(FAST_SIM)
  ) u_soft_start_tmr (
    .clk   (clk),
    .rst_n (rst_n),
    .pwr_up(pwr_up),
    .ss_tmr(ss_tmr)
  );

endmodule
